// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add unsigned multiplier.
// A rising edge on start launches a fixed WIDTH-cycle multiply; product holds until the next result.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 start_d_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, done_q;
    logic                 launch_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   p_shift_s;

    assign launch_s  = start & ~start_d_q;
    // Carry out of the high-half add is kept so the top product bit survives the shift.
    assign sum_s     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    assign p_shift_s = {sum_s, p_q[WIDTH-1:1]};

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        p_d       = p_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch_s) begin
                    m_d     = a;
                    p_d     = {{WIDTH{1'b0}}, b};
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                p_d   = p_shift_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    product_d = p_shift_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            start_d_q <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            m_q       <= {WIDTH{1'b0}};
            p_q       <= {(2*WIDTH){1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_d_q <= start;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            p_q       <= p_d;
            product_q <= product_d;
            busy_q    <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed scenarios plus random launches,
// compared every cycle against a countdown/arithmetic reference model.
module tb_mult_seq;

    localparam int W = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   product;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    mult_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: rem counts remaining RUN cycles; result is plain a*b captured at launch.
    int           rem_m        = 0;
    logic [63:0]  op_m         = 64'd0;
    logic [63:0]  prod_m       = 64'd0;
    logic         done_m       = 1'b0;
    logic         prev_start_m = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_m        <= 0;
            op_m         <= 64'd0;
            prod_m       <= 64'd0;
            done_m       <= 1'b0;
            prev_start_m <= 1'b0;
        end else begin
            done_m       <= 1'b0;
            prev_start_m <= start;
            if (rem_m > 0) begin
                rem_m <= rem_m - 1;
                if (rem_m == 1) begin
                    prod_m <= op_m;
                    done_m <= 1'b1;
                end
            end else if (start && !prev_start_m) begin
                rem_m <= W;
                op_m  <= {32'd0, a} * {32'd0, b};
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("product", product, prod_m);
            check("busy", {63'd0, busy}, {63'd0, (rem_m > 0)});
            check("done", {63'd0, done}, {63'd0, done_m});
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && !done; i++) cycles(1);
        check(tag, {63'd0, done}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom);
            a     = $urandom;
            b     = $urandom;
            cycles(1);
            check("rst_product", product, 64'd0);
            check("rst_busy", {63'd0, busy}, 64'd0);
            check("rst_done", {63'd0, done}, 64'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        busy_cnt = 0;
        cycles(20);
        check("idle_busy_cnt", 64'(busy_cnt), 64'd0);

        // Basic 3*5 with start held 40 cycles
        done_cnt = 0; busy_cnt = 0;
        a = 32'd3; b = 32'd5; start = 1'b1;
        cycles(40);
        start = 1'b0;
        cycles(5);
        check("basic_product", product, 64'd15);
        check("basic_done_cnt", 64'(done_cnt), 64'd1);
        check("basic_busy_cnt", 64'(busy_cnt), 64'd32);

        // Max operands
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        cycles(40);
        start = 1'b0;
        check("max_product", product, 64'hFFFF_FFFE_0000_0001);
        cycles(3);

        // Operand changes and re-trigger during RUN are ignored
        done_cnt = 0;
        a = 32'h1234; b = 32'h10; start = 1'b1;
        cycles(5);
        a = 32'hDEAD_BEEF; b = 32'h7;
        start = 1'b0;
        cycles(1);
        start = 1'b1;
        cycles(40);
        start = 1'b0;
        cycles(5);
        check("ignore_product", product, 64'h12340);
        check("ignore_done_cnt", 64'(done_cnt), 64'd1);

        // Back-to-back: relaunch in the DONE cycle
        a = 32'd7; b = 32'd6; start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(1);
        wait_done("b2b_first_done");
        check("b2b_first_product", product, 64'd42);
        a = 32'd2; b = 32'd9; start = 1'b1;
        cycles(1);
        check("b2b_busy_again", {63'd0, busy}, 64'd1);
        start = 1'b0;
        cycles(15);
        check("b2b_hold_42", product, 64'd42);
        wait_done("b2b_second_done");
        check("b2b_second_product", product, 64'd18);
        cycles(5);

        // Reset mid-operation, then relaunch on release with start still high
        a = 32'd100; b = 32'd100; start = 1'b1;
        cycles(11);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_product", product, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        cycles(2);
        done_cnt = 0;
        rst_n = 1'b1;
        cycles(36);
        check("midrst_relaunch_product", product, 64'd10000);
        check("midrst_done_cnt", 64'(done_cnt), 64'd1);
        start = 1'b0;
        cycles(5);

        // Random launches, holds, re-triggers and gaps
        for (int it = 0; it < 25; it++) begin
            a = $urandom;
            b = (it % 5 == 0) ? 32'd0 : $urandom;
            start = 1'b1;
            cycles($urandom_range(1, 40));
            if ($urandom_range(0, 1) == 1) begin
                start = 1'b0;
                cycles(1);
                a = $urandom;
                start = 1'b1;
                cycles(1);
            end
            start = 1'b0;
            cycles($urandom_range(0, 6));
        end
        cycles(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
